// File: rtl/noc_pkg.sv
// Shared constants and types for the NoC virtual-channel input port.
package noc_pkg;

  localparam int unsigned NOC_DATA_W = 16;
  localparam int unsigned NOC_DEPTH  = 5;
  localparam int unsigned NOC_NUM_VC = 2;

  typedef logic [NOC_DATA_W-1:0] flit_t;

  // VC index width; a single VC still needs one bit of index.
  function automatic int unsigned vc_width(input int unsigned num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Single virtual-channel circular FIFO with combinational head output.
module noc_vc_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 5,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // A pop frees the slot the push is about to overwrite when full.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pop_ok) begin
      rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
    end
    if (push_ok) begin
      wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/noc_vc_input_port.sv
// NoC input port: per-VC FIFOs, round-robin output grant and credit return.
// Define NOC_INPORT_ERR_EN to enable the sticky protocol-error flag err_o.
module noc_vc_input_port
  import noc_pkg::*;
#(
  parameter int unsigned DATA_W = NOC_DATA_W,
  parameter int unsigned DEPTH  = NOC_DEPTH,
  parameter int unsigned NUM_VC = NOC_NUM_VC,
  localparam int unsigned VC_W  = vc_width(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic [VC_W-1:0]   vc_i,
  input  logic              write_en,
  input  logic              shift,
  output logic [DATA_W-1:0] data_o,
  output logic [VC_W-1:0]   vc_o,
  output logic              read_valid_o,
  output logic [NUM_VC-1:0] credit_o,
  output logic [NUM_VC-1:0] full_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] head [NUM_VC];
  logic [CNT_W-1:0]  cnt  [NUM_VC];
  logic [NUM_VC-1:0] fifo_full, fifo_empty, push_vc, pop_vc;
  logic [VC_W-1:0]   gnt, gnt_q, rr_q, rr_d;
  logic [NUM_VC-1:0] credit_q;
  logic              lock_q, valid, pop, push_ok, vc_ok, found;

  assign valid = ~&fifo_empty;
  assign vc_ok = (32'(vc_i) < NUM_VC);
  assign pop   = shift & valid & ~rst;
  assign push_ok = write_en & ~rst & vc_ok &
                   (~fifo_full[vc_i] | (pop & (gnt == vc_i)));

  // A presented, unpopped flit locks the grant; otherwise search from rr_q.
  always_comb begin
    gnt   = gnt_q;
    found = 1'b0;
    if (!lock_q) begin
      gnt = '0;
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        if (!found && !fifo_empty[VC_W'((32'(rr_q) + i) % NUM_VC)]) begin
          gnt   = VC_W'((32'(rr_q) + i) % NUM_VC);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (pop) begin
      rr_d = (gnt == VC_W'(NUM_VC - 1)) ? '0 : gnt + VC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q    <= '0;
      rr_q     <= '0;
      lock_q   <= 1'b0;
      credit_q <= '0;
    end else begin
      gnt_q    <= gnt;
      rr_q     <= rr_d;
      lock_q   <= valid & ~shift;
      credit_q <= pop_vc;
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push_vc[v] = push_ok & (vc_i == VC_W'(v));
    assign pop_vc[v]  = pop & (gnt == VC_W'(v));
    assign full_o[v]  = (cnt[v] == CNT_W'(DEPTH));

    noc_vc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_vc[v]),
      .pop_i   (pop_vc[v]),
      .data_i  (data_i),
      .data_o  (head[v]),
      .full_o  (fifo_full[v]),
      .empty_o (fifo_empty[v]),
      .count_o (cnt[v])
    );
  end

  assign data_o       = valid ? head[gnt] : '0;
  assign vc_o         = valid ? gnt : '0;
  assign read_valid_o = valid;
  assign credit_o     = credit_q;

`ifdef NOC_INPORT_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((write_en & ~push_ok) | (shift & ~valid)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_vc_input_port.sv
// Directed bench for noc_vc_input_port (default parameters).
module tb_noc_vc_input_port;
  import noc_pkg::*;

`ifdef NOC_INPORT_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  flit_t      data_i;
  logic [0:0] vc_i;
  logic       write_en, shift;
  flit_t      data_o;
  logic [0:0] vc_o;
  logic       read_valid_o;
  logic [1:0] credit_o, full_o;
  logic       err_o;

  int tests = 0;
  int fails = 0;

  noc_vc_input_port dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .vc_i         (vc_i),
    .write_en     (write_en),
    .shift        (shift),
    .data_o       (data_o),
    .vc_o         (vc_o),
    .read_valid_o (read_valid_o),
    .credit_o     (credit_o),
    .full_o       (full_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [0:0] vc, input logic [15:0] d);
    write_en = 1'b1;
    vc_i     = vc;
    data_i   = d;
    tick();
    write_en = 1'b0;
  endtask

  task automatic pop();
    shift = 1'b1;
    tick();
    shift = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data_i = '0; vc_i = '0; write_en = 1'b0; shift = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(read_valid_o), 0);
    chk("rst_credit", 32'(credit_o), 0);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_data", 32'(data_o), 0);

    // Single flit latency and credit pulse
    push(1'b0, 16'h1111);
    chk("t1_valid", 32'(read_valid_o), 1);
    chk("t1_data", 32'(data_o), 32'h1111);
    chk("t1_vc", 32'(vc_o), 0);
    chk("t1_nocredit", 32'(credit_o), 0);
    pop();
    chk("t1_credit", 32'(credit_o), 32'b01);
    chk("t1_empty", 32'(read_valid_o), 0);
    tick();
    chk("t1_credit_off", 32'(credit_o), 0);

    // Fill VC1, overflow drop
    for (int i = 0; i < 5; i++) push(1'b1, 16'h2000 + 16'(i));
    chk("t2_full", 32'(full_o), 32'b10);
    chk("t2_vc", 32'(vc_o), 1);
    push(1'b1, 16'h2005);
    chk("t2_full_after_drop", 32'(full_o), 32'b10);
    chk("t2_err", 32'(err_o), 32'(ErrEn));
    for (int i = 0; i < 5; i++) begin
      chk("t2_drain", 32'(data_o), 32'h2000 + 32'(i));
      pop();
    end
    chk("t2_empty", 32'(read_valid_o), 0);
    chk("t2_credit", 32'(credit_o), 32'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t2_err_clr", 32'(err_o), 0);

    // Round-robin order
    push(1'b0, 16'hA000);
    push(1'b0, 16'hA001);
    push(1'b1, 16'hB000);
    push(1'b1, 16'hB001);
    chk("t3_a0", 32'(data_o), 32'hA000);
    shift = 1'b1;
    tick();
    chk("t3_b0", 32'(data_o), 32'hB000);
    chk("t3_b0_vc", 32'(vc_o), 1);
    chk("t3_cr0", 32'(credit_o), 32'b01);
    tick();
    chk("t3_a1", 32'(data_o), 32'hA001);
    chk("t3_cr1", 32'(credit_o), 32'b10);
    tick();
    chk("t3_b1", 32'(data_o), 32'hB001);
    tick();
    shift = 1'b0;
    chk("t3_empty", 32'(read_valid_o), 0);
    chk("t3_cr3", 32'(credit_o), 32'b10);

    // Push and pop on a full VC
    for (int i = 0; i < 5; i++) push(1'b0, 16'hC000 + 16'(i));
    chk("t4_full", 32'(full_o), 32'b01);
    chk("t4_head", 32'(data_o), 32'hC000);
    write_en = 1'b1; vc_i = 1'b0; data_i = 16'hC005; shift = 1'b1;
    tick();
    write_en = 1'b0; shift = 1'b0;
    chk("t4_still_full", 32'(full_o), 32'b01);
    chk("t4_no_err", 32'(err_o), 0);
    chk("t4_credit", 32'(credit_o), 32'b01);
    for (int i = 1; i < 6; i++) begin
      chk("t4_drain", 32'(data_o), 32'hC000 + 32'(i));
      pop();
    end
    chk("t4_empty", 32'(read_valid_o), 0);

    // Grant holds while shift is low
    push(1'b0, 16'hD000);
    chk("t5_head", 32'(data_o), 32'hD000);
    push(1'b1, 16'hE000);
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_data", 32'(data_o), 32'hD000);
      chk("t5_hold_vc", 32'(vc_o), 0);
      tick();
    end
    pop();
    chk("t5_next", 32'(data_o), 32'hE000);
    chk("t5_next_vc", 32'(vc_o), 1);
    chk("t5_credit", 32'(credit_o), 32'b01);
    pop();
    chk("t5_empty", 32'(read_valid_o), 0);

    // Mid-stream reset discards flits without credits
    push(1'b0, 16'hF000);
    push(1'b1, 16'hF001);
    push(1'b0, 16'hF002);
    rst = 1'b1; write_en = 1'b1; vc_i = 1'b0; data_i = 16'hFFFF; shift = 1'b1;
    tick();
    rst = 1'b0; write_en = 1'b0; shift = 1'b0;
    chk("t6_valid", 32'(read_valid_o), 0);
    chk("t6_credit", 32'(credit_o), 0);
    chk("t6_full", 32'(full_o), 0);
    chk("t6_err", 32'(err_o), 0);
    tick();
    chk("t6_valid2", 32'(read_valid_o), 0);
    chk("t6_credit2", 32'(credit_o), 0);
    push(1'b1, 16'h6000);
    chk("t6_push_valid", 32'(read_valid_o), 1);
    chk("t6_push_data", 32'(data_o), 32'h6000);
    chk("t6_push_vc", 32'(vc_o), 1);

    // Shift with nothing presented
    pop();
    chk("t7_credit", 32'(credit_o), 32'b10);
    pop();
    chk("t7_ign_credit", 32'(credit_o), 0);
    chk("t7_ign_valid", 32'(read_valid_o), 0);
    chk("t7_err", 32'(err_o), 32'(ErrEn));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noc_vc_input_port.md
NOC_VC_INPUT_PORT -- requirements
Module: noc_vc_input_port

Interface
REQ-001 Parameter DATA_W, default 16, flit width in bits.
REQ-002 Parameter DEPTH, default 5, flits per VC FIFO; legal range 2..64.
REQ-003 Parameter NUM_VC, default 2, number of virtual channels; legal range 1..8; VC_W = max(1, clog2(NUM_VC)).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 data_i  input  DATA_W  incoming flit.
REQ-007 vc_i  input  VC_W  target VC of the incoming flit.
REQ-008 write_en  input  1  push data_i into FIFO vc_i.
REQ-009 shift  input  1  pop the flit currently presented on data_o.
REQ-010 data_o  output  DATA_W  head flit of the granted VC.
REQ-011 vc_o  output  VC_W  index of the granted VC.
REQ-012 read_valid_o  output  1  data_o/vc_o hold a valid flit.
REQ-013 credit_o  output  NUM_VC  one-cycle pulse per VC when a flit leaves that VC.
REQ-014 full_o  output  NUM_VC  per-VC full flags.
REQ-015 err_o  output  1  sticky protocol-error flag.

Function
REQ-016 Each VC SHALL own an independent circular FIFO of DEPTH entries, with read pointer, write pointer and a count of width clog2(DEPTH+1); both pointers wrap from DEPTH-1 to 0.
REQ-017 Push SHALL be accepted when write_en=1 and either FIFO vc_i is not full or the same VC is popped in the same cycle.
REQ-018 A write_en with vc_i >= NUM_VC, or to a full VC that is not popped in the same cycle, SHALL be dropped and leave FIFO state unchanged.
REQ-019 Output SHALL be registered first-word-fall-through: a flit pushed into an empty system in cycle N appears with read_valid_o=1 in cycle N+1.
REQ-020 The granted VC SHALL be chosen by round-robin among non-empty VCs, starting from the VC after the last popped VC.
REQ-021 The grant SHALL be held stable while read_valid_o=1 and shift=0; data_o and vc_o SHALL NOT change until the flit is popped.
REQ-022 shift=1 with read_valid_o=1 SHALL pop the granted VC, pulse credit_o[vc_o] in the next cycle, and advance the round-robin pointer to vc_o+1 mod NUM_VC.
REQ-023 shift=1 with read_valid_o=0 SHALL be ignored.
REQ-024 A simultaneous push and pop on the same VC SHALL leave its count unchanged, including when the VC is full or holds exactly one entry.
REQ-025 full_o[v] SHALL equal (count[v]==DEPTH); read_valid_o SHALL be 1 iff any count is non-zero.

Reset
REQ-026 In any cycle with rst=1, all pointers, counts and the round-robin pointer SHALL go to 0, and data_o, vc_o, read_valid_o, credit_o, full_o and err_o SHALL go to 0.
REQ-027 During reset, write_en and shift SHALL be ignored; a reset issued mid-stream SHALL discard all stored flits without issuing credits.

Configuration
REQ-028 With macro NOC_INPORT_ERR_EN defined, err_o SHALL set on any dropped push (REQ-018) or ignored shift (REQ-023) and SHALL clear only on rst.
REQ-029 Without NOC_INPORT_ERR_EN, err_o SHALL be tied to 0, no error logic SHALL be present, and drop/ignore behaviour SHALL otherwise be identical.

Structure
REQ-030 Package noc_pkg SHALL hold the default DATA_W/DEPTH/NUM_VC constants and the flit_t typedef.
REQ-031 The per-VC storage SHALL be sub-module noc_vc_fifo (one FIFO with push, pop, full, empty and count), instantiated NUM_VC times in a generate loop; arbitration and credit logic SHALL reside in the top module.

Verification
REQ-032 Push 0x1111 on VC0 in cycle 1 -> read_valid_o=1, data_o=0x1111, vc_o=0 in cycle 2; shift -> credit_o=2'b01 for one cycle.
REQ-033 With NUM_VC=2 and DEPTH=5, push 5 flits on VC1 -> full_o=2'b10; a 6th push is dropped and err_o=1 (with NOC_INPORT_ERR_EN).
REQ-034 Fill VC0 with A0,A1 and VC1 with B0,B1, then shift continuously -> output order A0,B0,A1,B1.
REQ-035 With VC0 full, push and shift on VC0 in the same cycle -> count stays 5, no err_o, and the new flit emerges last.
REQ-036 Hold shift=0 for 10 cycles while a VC1 push arrives -> data_o and vc_o remain stable on the VC0 head.
REQ-037 Assert rst with 3 flits stored -> next cycle read_valid_o=0, credit_o=0, full_o=0, err_o=0; a subsequent push appears in 1 cycle.
